// File: rtl/noc_input_port_requester_pkg.sv
// Shared types and constants for the NoC input-port requester: flit types,
// output-port indices, flit field geometry and the request watchdog limit.
package noc_input_port_requester_pkg;

  localparam int NOC_VC_CHANNEL     = 2;
  localparam int NOC_PORTS          = 5;
  localparam int PORT_LOCAL         = 0;
  localparam int PORT_EAST          = 1;
  localparam int PORT_WEST          = 2;
  localparam int PORT_NORTH         = 3;
  localparam int PORT_SOUTH         = 4;

  // Flit layout from the MSB down: type, dest X, dest Y, payload.
  localparam int FLIT_TYPE_W        = 2;

  localparam int NOC_WATCHDOG_LIMIT = 1024;
  localparam int NOC_WATCHDOG_W     = 16;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    VC_IDLE,
    VC_REQ,
    VC_XFER
  } vc_state_e;

  function automatic logic is_head_type(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  function automatic logic is_last_type(input flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Per-VC flit FIFO. DEPTH must be a power of two; FLAG_FF_OUT=1 registers the
// full/empty flags so downstream ready is a clean flop output.
module noc_fifo #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 4,
  parameter bit FLAG_FF_OUT = 1'b1
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_cnt, w_cnt_nxt;
  logic              w_push, w_pop;

  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge noc_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  generate
    if (FLAG_FF_OUT) begin : g_flag_ff
      logic r_full, r_empty;
      always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
          r_full  <= 1'b0;
          r_empty <= 1'b1;
        end else begin
          r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
          r_empty <= (w_cnt_nxt == '0);
        end
      end
      assign o_full  = r_full;
      assign o_empty = r_empty;
    end else begin : g_flag_comb
      assign o_full  = (r_cnt == (AW+1)'(DEPTH));
      assign o_empty = (r_cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/noc_input_port_requester_vc.sv
// One virtual channel: FIFO, route latch and IDLE/REQ/XFER claim FSM.
// NOC_REQ_WATCHDOG_EN adds a sticky timeout on long REQ waits.
module noc_input_port_requester_vc
  import noc_input_port_requester_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int FLIT_W  = 64,
  parameter int XY_W    = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic                 noc_clk,
  input  logic                 noc_rst_n,
  input  logic                 i_valid,
  input  logic [FLIT_W-1:0]    i_flit,
  output logic                 o_ready,
  input  logic [NOC_PORTS-1:0] i_grant,
  output logic [NOC_PORTS-1:0] o_sop,
  output logic [NOC_PORTS-1:0] o_req,
  output logic [NOC_PORTS-1:0] o_eop,
  output logic [NOC_PORTS-1:0] o_free,
  output logic                 o_valid,
  output logic [FLIT_W-1:0]    o_flit,
  output logic [NOC_PORTS-1:0] o_port
`ifdef NOC_REQ_WATCHDOG_EN
  ,
  output logic                 o_err_timeout
`endif
);

  localparam int X_MSB = FLIT_W - 1 - FLIT_TYPE_W;
  localparam int Y_MSB = X_MSB - XY_W;

  vc_state_e            r_state;
  logic [NOC_PORTS-1:0] r_port;
  logic [FLIT_W-1:0]    w_head;
  logic                 w_full, w_empty, w_pop;
  logic                 w_granted, w_xfer, w_last;
  logic [NOC_PORTS-1:0] w_route;
  flit_type_e           w_type;

  noc_fifo #(.DATA_W(FLIT_W), .DEPTH(DEPTH), .FLAG_FF_OUT(1'b1)) u_fifo (
    .noc_clk  (noc_clk),
    .noc_rst_n(noc_rst_n),
    .i_push   (i_valid),
    .i_data   (i_flit),
    .i_pop    (w_pop),
    .o_data   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  noc_xy_route_calc #(.XY_W(XY_W)) u_route (
    .i_dst_x(w_head[X_MSB -: XY_W]),
    .i_dst_y(w_head[Y_MSB -: XY_W]),
    .i_loc_x(XY_W'(LOCAL_X)),
    .i_loc_y(XY_W'(LOCAL_Y)),
    .o_port (w_route)
  );

  assign w_type    = flit_type_e'(w_head[FLIT_W-1 -: FLIT_TYPE_W]);
  assign w_granted = |(i_grant & r_port);
  // A grant in REQ already moves a flit, so the first transfer does not wait for XFER.
  assign w_xfer    = (r_state != VC_IDLE) & w_granted & ~w_empty;
  assign w_last    = w_xfer & is_last_type(w_type);
  assign w_pop     = w_xfer | ((r_state == VC_IDLE) & ~w_empty & ~is_head_type(w_type));

  assign o_ready = ~w_full;
  assign o_sop   = (r_state == VC_REQ) ? r_port : '0;
  assign o_req   = (r_state != VC_IDLE) ? r_port : '0;
  assign o_eop   = w_last ? r_port : '0;
  assign o_free  = w_last ? r_port : '0;
  assign o_valid = w_xfer;
  assign o_flit  = w_xfer ? w_head : '0;
  assign o_port  = w_xfer ? r_port : '0;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state <= VC_IDLE;
      r_port  <= '0;
    end else begin
      case (r_state)
        VC_IDLE: if (!w_empty && is_head_type(w_type)) begin
          r_port  <= w_route;
          r_state <= VC_REQ;
        end
        VC_REQ:  if (w_last) r_state <= VC_IDLE;
                 else if (w_granted) r_state <= VC_XFER;
        VC_XFER: if (w_last) r_state <= VC_IDLE;
        default: r_state <= VC_IDLE;
      endcase
    end
  end

`ifdef NOC_REQ_WATCHDOG_EN
  logic [NOC_WATCHDOG_W-1:0] r_wd_cnt;
  logic                      r_err;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else if (r_state == VC_REQ) begin
      if (r_wd_cnt != '1) r_wd_cnt <= r_wd_cnt + 1'b1;
      if (r_wd_cnt >= NOC_WATCHDOG_W'(NOC_WATCHDOG_LIMIT - 1)) r_err <= 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign o_err_timeout = r_err;
`endif

endmodule

// File: rtl/noc_xy_route_calc.sv
// Dimension-ordered XY route: resolve X first, then Y; returns a one-hot port.
module noc_xy_route_calc
  import noc_input_port_requester_pkg::*;
#(
  parameter int XY_W = 4
) (
  input  logic [XY_W-1:0]      i_dst_x,
  input  logic [XY_W-1:0]      i_dst_y,
  input  logic [XY_W-1:0]      i_loc_x,
  input  logic [XY_W-1:0]      i_loc_y,
  output logic [NOC_PORTS-1:0] o_port
);

  always_comb begin
    o_port = '0;
    if (i_dst_x > i_loc_x)      o_port[PORT_EAST]  = 1'b1;
    else if (i_dst_x < i_loc_x) o_port[PORT_WEST]  = 1'b1;
    else if (i_dst_y > i_loc_y) o_port[PORT_NORTH] = 1'b1;
    else if (i_dst_y < i_loc_y) o_port[PORT_SOUTH] = 1'b1;
    else                        o_port[PORT_LOCAL] = 1'b1;
  end

endmodule

// File: rtl/noc_input_port_requester.sv
// Router input port: per-VC buffering, XY routing and port claim/release
// toward the output controllers. NOC_REQ_WATCHDOG_EN adds err_timeout.
module noc_input_port_requester
  import noc_input_port_requester_pkg::*;
#(
  parameter int CHANNELS = NOC_VC_CHANNEL,
  parameter int DEPTH    = 4,
  parameter int FLIT_W   = 64,
  parameter int XY_W     = 4,
  parameter int LOCAL_X  = 0,
  parameter int LOCAL_Y  = 0
) (
  input  logic                                 noc_clk,
  input  logic                                 noc_rst_n,
  input  logic [CHANNELS-1:0]                  in_valid,
  input  logic [CHANNELS-1:0][FLIT_W-1:0]      in_flit,
  output logic [CHANNELS-1:0]                  in_ready,
  output logic [NOC_PORTS-1:0][CHANNELS-1:0]   start_of_packet,
  output logic [NOC_PORTS-1:0][CHANNELS-1:0]   request,
  output logic [NOC_PORTS-1:0][CHANNELS-1:0]   end_of_packet,
  output logic [NOC_PORTS-1:0][CHANNELS-1:0]   free,
  input  logic [NOC_PORTS-1:0][CHANNELS-1:0]   grant,
  output logic [CHANNELS-1:0]                  out_valid,
  output logic [CHANNELS-1:0][FLIT_W-1:0]      out_flit,
  output logic [CHANNELS-1:0][NOC_PORTS-1:0]   out_port
`ifdef NOC_REQ_WATCHDOG_EN
  ,
  output logic [CHANNELS-1:0]                  err_timeout
`endif
);

  logic [CHANNELS-1:0][NOC_PORTS-1:0] w_grant, w_sop, w_req, w_eop, w_free;

  // Controllers index [port][vc]; the VC lanes work on [vc][port].
  always_comb begin
    w_grant         = '0;
    start_of_packet = '0;
    request         = '0;
    end_of_packet   = '0;
    free            = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int p = 0; p < NOC_PORTS; p++) begin
        w_grant[c][p]         = grant[p][c];
        start_of_packet[p][c] = w_sop[c][p];
        request[p][c]         = w_req[c][p];
        end_of_packet[p][c]   = w_eop[c][p];
        free[p][c]            = w_free[c][p];
      end
    end
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
      noc_input_port_requester_vc #(
        .DEPTH  (DEPTH),
        .FLIT_W (FLIT_W),
        .XY_W   (XY_W),
        .LOCAL_X(LOCAL_X),
        .LOCAL_Y(LOCAL_Y)
      ) u_vc (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .i_valid      (in_valid[c]),
        .i_flit       (in_flit[c]),
        .o_ready      (in_ready[c]),
        .i_grant      (w_grant[c]),
        .o_sop        (w_sop[c]),
        .o_req        (w_req[c]),
        .o_eop        (w_eop[c]),
        .o_free       (w_free[c]),
        .o_valid      (out_valid[c]),
        .o_flit       (out_flit[c]),
        .o_port       (out_port[c])
`ifdef NOC_REQ_WATCHDOG_EN
        ,
        .o_err_timeout(err_timeout[c])
`endif
      );
    end
  endgenerate

endmodule

// File: tb/tb_noc_input_port_requester.sv
// Self-checking bench: route vector table plus directed multi-cycle sequences,
// with a per-VC scoreboard checking every flit leaving the crossbar side.
module tb_noc_input_port_requester;
  import noc_input_port_requester_pkg::*;

  localparam int CH = 2, DEPTH = 4, FW = 64, XYW = 4, LX = 2, LY = 2;

  logic                   noc_clk   = 1'b0;
  logic                   noc_rst_n = 1'b0;
  logic [CH-1:0]          in_valid  = '0;
  logic [CH-1:0][FW-1:0]  in_flit   = '0;
  logic [CH-1:0]          in_ready;
  logic [4:0][CH-1:0]     start_of_packet, request, end_of_packet, free;
  logic [4:0][CH-1:0]     grant     = '0;
  logic [CH-1:0]          out_valid;
  logic [CH-1:0][FW-1:0]  out_flit;
  logic [CH-1:0][4:0]     out_port;
`ifdef NOC_REQ_WATCHDOG_EN
  logic [CH-1:0]          err_timeout;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { logic [FW-1:0] flit; logic [4:0] port; logic last; } exp_t;
  typedef struct { logic [1:0] ty; logic [XYW-1:0] dx; logic [XYW-1:0] dy; logic [4:0] port; } vec_t;

  exp_t sb [CH][$];
  vec_t vecs [8];

  noc_input_port_requester #(
    .CHANNELS(CH), .DEPTH(DEPTH), .FLIT_W(FW), .XY_W(XYW), .LOCAL_X(LX), .LOCAL_Y(LY)
  ) dut (
    .noc_clk        (noc_clk),
    .noc_rst_n      (noc_rst_n),
    .in_valid       (in_valid),
    .in_flit        (in_flit),
    .in_ready       (in_ready),
    .start_of_packet(start_of_packet),
    .request        (request),
    .end_of_packet  (end_of_packet),
    .free           (free),
    .grant          (grant),
    .out_valid      (out_valid),
    .out_flit       (out_flit),
    .out_port       (out_port)
`ifdef NOC_REQ_WATCHDOG_EN
    ,
    .err_timeout    (err_timeout)
`endif
  );

  always #5 noc_clk = ~noc_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] col(input logic [4:0][CH-1:0] a, input int c);
    logic [4:0] r;
    for (int p = 0; p < 5; p++) r[p] = a[p][c];
    return r;
  endfunction

  function automatic logic [FW-1:0] mk(input logic [1:0] ty, input logic [XYW-1:0] dx,
                                       input logic [XYW-1:0] dy, input logic [31:0] pl);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1 -: 2]       = ty;
    f[FW-3 -: XYW]     = dx;
    f[FW-3-XYW -: XYW] = dy;
    f[31:0]            = pl;
    return f;
  endfunction

  task automatic send(input int c, input logic [FW-1:0] f, input logic exp, input logic [4:0] port);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready[c] && n < 50) begin
      @(posedge noc_clk); #1;
      n++;
    end
    if (!in_ready[c]) chk("send_ready", 64'(in_ready[c]), 64'd1);
    if (exp) begin
      e.flit = f;
      e.port = port;
      e.last = (f[FW-1 -: 2] == 2'b10) || (f[FW-1 -: 2] == 2'b11);
      sb[c].push_back(e);
    end
    in_flit[c]  = f;
    in_valid[c] = 1'b1;
    @(posedge noc_clk); #1;
    in_valid[c] = 1'b0;
  endtask

  task automatic wait_drain(input int c, input string name);
    int n;
    n = 0;
    while (sb[c].size() != 0 && n < 20) begin
      @(posedge noc_clk);
      n++;
    end
    @(negedge noc_clk);
    chk(name, 64'(sb[c].size()), 64'd0);
    sb[c].delete();
    @(posedge noc_clk); #1;
  endtask

  // Scoreboard: every presented flit must match the next expected one.
  always @(negedge noc_clk) begin
    exp_t e;
    if (noc_rst_n) begin
      for (int c = 0; c < CH; c++) begin
        if (out_valid[c]) begin
          if (sb[c].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected vc%0d: got flit %0h expected none", c, out_flit[c]);
          end else begin
            e = sb[c].pop_front();
            chk("sb_flit", out_flit[c], e.flit);
            chk("sb_port", 64'(out_port[c]), 64'(e.port));
            chk("sb_eop",  64'(col(end_of_packet, c)), e.last ? 64'(e.port) : 64'd0);
            chk("sb_free", 64'(col(free, c)),          e.last ? 64'(e.port) : 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{ty: 2'b11, dx: 4'd2, dy: 4'd2, port: 5'b00001};
    vecs[1] = '{ty: 2'b11, dx: 4'd4, dy: 4'd2, port: 5'b00010};
    vecs[2] = '{ty: 2'b11, dx: 4'd0, dy: 4'd2, port: 5'b00100};
    vecs[3] = '{ty: 2'b11, dx: 4'd2, dy: 4'd5, port: 5'b01000};
    vecs[4] = '{ty: 2'b11, dx: 4'd2, dy: 4'd0, port: 5'b10000};
    vecs[5] = '{ty: 2'b11, dx: 4'd3, dy: 4'd0, port: 5'b00010};
    vecs[6] = '{ty: 2'b11, dx: 4'd1, dy: 4'd7, port: 5'b00100};
    vecs[7] = '{ty: 2'b11, dx: 4'd15, dy: 4'd15, port: 5'b00010};

    // Reset state
    repeat (3) @(posedge noc_clk);
    #1;
    chk("rst_in_ready",  64'(in_ready), 64'(2'b11));
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sop",       64'(start_of_packet), 64'd0);
    chk("rst_req",       64'(request), 64'd0);
    chk("rst_eop",       64'(end_of_packet), 64'd0);
    chk("rst_free",      64'(free), 64'd0);
    noc_rst_n = 1'b1;
    @(posedge noc_clk); #1;

    // SINGLE to local with grant tied high: two-cycle latency, sop/eop/free together
    grant = '1;
    send(0, mk(2'b11, 4'd2, 4'd2, 32'h11), 1'b1, 5'b00001);
    @(negedge noc_clk);
    chk("t1_sop_early",   64'(col(start_of_packet, 0)), 64'd0);
    chk("t1_valid_early", 64'(out_valid[0]), 64'd0);
    @(negedge noc_clk);
    chk("t1_sop",   64'(col(start_of_packet, 0)), 64'(5'b00001));
    chk("t1_valid", 64'(out_valid[0]), 64'd1);
    chk("t1_eop",   64'(col(end_of_packet, 0)), 64'(5'b00001));
    chk("t1_free",  64'(col(free, 0)), 64'(5'b00001));
    @(negedge noc_clk);
    chk("t1_sop_after",   64'(col(start_of_packet, 0)), 64'd0);
    chk("t1_valid_after", 64'(out_valid[0]), 64'd0);
    @(posedge noc_clk); #1;

    // Route table
    for (int i = 0; i < 8; i++) begin
      send(0, mk(vecs[i].ty, vecs[i].dx, vecs[i].dy, 32'h100 + i), 1'b1, vecs[i].port);
      wait_drain(0, "route_drain");
    end

    // 4-flit packet east, grant withheld then streamed
    grant = '0;
    send(0, mk(2'b00, 4'd4, 4'd2, 32'h200), 1'b1, 5'b00010);
    send(0, mk(2'b01, 4'd4, 4'd2, 32'h201), 1'b1, 5'b00010);
    send(0, mk(2'b01, 4'd4, 4'd2, 32'h202), 1'b1, 5'b00010);
    send(0, mk(2'b10, 4'd4, 4'd2, 32'h203), 1'b1, 5'b00010);
    for (int i = 0; i < 5; i++) begin
      @(negedge noc_clk);
      chk("t2_req_hold",  64'(col(request, 0)), 64'(5'b00010));
      chk("t2_no_valid",  64'(out_valid[0]), 64'd0);
    end
    @(posedge noc_clk); #1;
    grant[1][0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge noc_clk);
      chk("t2_stream_valid", 64'(out_valid[0]), 64'd1);
      chk("t2_stream_free",  64'(col(free, 0)), (i == 3) ? 64'(5'b00010) : 64'd0);
    end
    @(negedge noc_clk);
    chk("t2_done_valid", 64'(out_valid[0]), 64'd0);
    chk("t2_done_req",   64'(col(request, 0)), 64'd0);
    wait_drain(0, "t2_drain");
    grant = '0;

    // Fill VC1 with no grant: in_ready drops, one pop restores it
    send(1, mk(2'b00, 4'd0, 4'd2, 32'h300), 1'b1, 5'b00100);
    send(1, mk(2'b01, 4'd0, 4'd2, 32'h301), 1'b1, 5'b00100);
    send(1, mk(2'b01, 4'd0, 4'd2, 32'h302), 1'b1, 5'b00100);
    send(1, mk(2'b10, 4'd0, 4'd2, 32'h303), 1'b1, 5'b00100);
    chk("t3_full", 64'(in_ready[1]), 64'd0);
    grant[2][1] = 1'b1;
    @(posedge noc_clk); #1;
    grant[2][1] = 1'b0;
    chk("t3_ready_again", 64'(in_ready[1]), 64'd1);
    chk("t3_sb_left",     64'(sb[1].size()), 64'd3);
    grant[2][1] = 1'b1;
    wait_drain(1, "t3_drain");
    grant = '0;

    // Stray BODY dropped in IDLE; grants while idle have no effect
    grant = '1;
    send(0, mk(2'b01, 4'd2, 4'd5, 32'h400), 1'b0, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(negedge noc_clk);
      chk("t4_no_sop",   64'(col(start_of_packet, 0)), 64'd0);
      chk("t4_no_valid", 64'(out_valid[0]), 64'd0);
    end
    @(posedge noc_clk); #1;
    send(0, mk(2'b00, 4'd2, 4'd5, 32'h401), 1'b1, 5'b01000);
    send(0, mk(2'b10, 4'd2, 4'd5, 32'h402), 1'b1, 5'b01000);
    wait_drain(0, "t4_drain");

    // Reset mid-XFER
    grant = '0;
    grant[1][0] = 1'b1;
    send(0, mk(2'b00, 4'd4, 4'd2, 32'h500), 1'b1, 5'b00010);
    send(0, mk(2'b01, 4'd4, 4'd2, 32'h501), 1'b1, 5'b00010);
    wait_drain(0, "t5_drain");
    send(1, mk(2'b00, 4'd4, 4'd2, 32'h502), 1'b0, 5'b00000);
    @(negedge noc_clk);
    chk("t5_claim_kept", 64'(col(request, 0)), 64'(5'b00010));
    chk("t5_stall",      64'(out_valid[0]), 64'd0);
    @(posedge noc_clk); #2;
    noc_rst_n = 1'b0;
    #1;
    chk("t5_rst_req",   64'(request), 64'd0);
    chk("t5_rst_free",  64'(free), 64'd0);
    chk("t5_rst_sop",   64'(start_of_packet), 64'd0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_ready", 64'(in_ready), 64'(2'b11));
    sb[0].delete();
    sb[1].delete();
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge noc_clk);
      chk("t5_post_ready", 64'(in_ready), 64'(2'b11));
      chk("t5_post_req",   64'(request), 64'd0);
    end
    @(posedge noc_clk); #1;
    grant = '1;
    send(0, mk(2'b11, 4'd2, 4'd2, 32'h503), 1'b1, 5'b00001);
    wait_drain(0, "t5_recover");
    grant = '0;

`ifdef NOC_REQ_WATCHDOG_EN
    chk("wd_clear", 64'(err_timeout), 64'd0);
    send(1, mk(2'b00, 4'd4, 4'd2, 32'h600), 1'b1, 5'b00010);
    repeat (1024) @(posedge noc_clk);
    #1;
    chk("wd_before_limit", 64'(err_timeout[1]), 64'd0);
    @(posedge noc_clk); #1;
    chk("wd_at_limit", 64'(err_timeout[1]), 64'd1);
    grant[1][1] = 1'b1;
    wait_drain(1, "wd_drain");
    repeat (10) @(posedge noc_clk);
    #1;
    chk("wd_sticky", 64'(err_timeout), 64'(2'b10));
    noc_rst_n = 1'b0;
    #1;
    chk("wd_rst_clear", 64'(err_timeout), 64'd0);
    noc_rst_n = 1'b1;
    grant = '0;
`endif

    repeat (2) @(posedge noc_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
